// File: rtl/core_task_loader_pkg.sv
// Shared definitions for the core-side task loader: state encodings,
// frame opcode field and default sizing.
package core_task_loader_pkg;

  // Opcode lives in the top byte of each instruction frame
  localparam int OP_W = 8;
  localparam logic [OP_W-1:0] STOP_OP_DEF = 8'hFF;

  // Default sizing shared with the scheduler side
  localparam int NUM_CORES_DEF = 4;
  localparam int FRAME_W_DEF   = 64;
  localparam int REG_W_DEF     = 8;
  localparam int BUF_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ld_state_e;

  // True when a frame's opcode marks the end of a task
  function automatic logic is_stop_op(input logic [OP_W-1:0] op,
                                      input logic [OP_W-1:0] stop);
    return op == stop;
  endfunction

endpackage

// File: rtl/core_task_loader_frame_ram.sv
// Frame store: one write port, one registered read port.
// Storage is not reset; only the read register is, so fetch_data is 0 out of reset.
module core_task_loader_frame_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; no reset on the array itself
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-cycle write to raddr returns the old word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/core_task_loader.sv
// Core-side end of the scheduler->core interface. Buffers the frames of
// one task, loads R0, releases the core with a run pulse and drives this
// core's Ready bit back to the scheduler.
module core_task_loader
  import core_task_loader_pkg::*;
#(
  parameter int              CORE_ID   = 0,
  parameter int              NUM_CORES = NUM_CORES_DEF,
  parameter int              FRAME_W   = FRAME_W_DEF,
  parameter int              REG_W     = REG_W_DEF,
  parameter int              BUF_DEPTH = BUF_DEPTH_DEF,
  parameter logic [OP_W-1:0] STOP_OP   = STOP_OP_DEF,
  parameter int              AW        = $clog2(BUF_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0]       Start,
  input  logic [FRAME_W-1:0]         Insn_Data,
  input  logic [NUM_CORES-1:0]       Init_R0_Vect,
  input  logic [NUM_CORES*REG_W-1:0] Init_R0,
  output logic                       Ready,
  input  logic [AW-1:0]              fetch_addr,
  output logic [FRAME_W-1:0]         fetch_data,
  output logic                       r0_we,
  output logic [REG_W-1:0]           r0_data,
  output logic                       core_run,
  input  logic                       core_halt,
  output logic [AW:0]                frame_cnt,
  output logic [1:0]                 err
);

  ld_state_e       state;
  logic            st;
  logic            stop_frame;
  logic            accept;
  logic            full;
  logic            run_pend;
  logic [AW:0]     cnt_base;
  logic [AW:0]     cnt_nxt;
  logic [AW-1:0]   wr_addr;

  // Only this core's slices are used; the rest belong to sibling loaders
  logic unused_inputs;
  assign unused_inputs = ^{Start, Init_R0_Vect, Init_R0};

  assign st         = Start[CORE_ID];
  assign stop_frame = is_stop_op(Insn_Data[FRAME_W-1 -: OP_W], STOP_OP);
  assign accept     = st && (state == IDLE || state == LOAD);

  // A new task always starts writing at slot 0
  assign cnt_base = (state == IDLE) ? '0 : frame_cnt;
  assign cnt_nxt  = cnt_base + (AW+1)'(1);
  assign wr_addr  = cnt_base[AW-1:0];
  // Last slot taken: the task is forced to run with whatever it has
  assign full     = (cnt_nxt == (AW+1)'(BUF_DEPTH));

  core_task_loader_frame_ram #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (FRAME_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (accept),
    .waddr (wr_addr),
    .wdata (Insn_Data),
    .raddr (fetch_addr),
    .rdata (fetch_data)
  );

  // Loader FSM with registered Ready / R0 / run pulses and sticky errors.
  // run_pend delays core_run by one cycle so it lands two cycles after the
  // final Start, never ahead of the R0 write issued one cycle after the first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      Ready     <= 1'b1;
      r0_we     <= 1'b0;
      r0_data   <= '0;
      core_run  <= 1'b0;
      run_pend  <= 1'b0;
      frame_cnt <= '0;
      err       <= '0;
    end else begin
      r0_we    <= 1'b0;
      run_pend <= 1'b0;
      core_run <= run_pend;
      case (state)
        IDLE, LOAD: begin
          if (st) begin
            Ready     <= 1'b0;
            frame_cnt <= cnt_nxt;
            if (state == IDLE && Init_R0_Vect[CORE_ID]) begin
              r0_we   <= 1'b1;
              r0_data <= Init_R0[CORE_ID*REG_W +: REG_W];
            end
            if (stop_frame || full) begin
              state    <= RUN;
              run_pend <= 1'b1;
              if (!stop_frame) err[0] <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end else begin
            Ready <= 1'b1;
          end
        end
        RUN: begin
          Ready <= 1'b0;
          if (st) err[1] <= 1'b1;
          // Halt wins over a simultaneous Start, which is dropped
          if (core_halt) begin
            state     <= IDLE;
            Ready     <= 1'b1;
            frame_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_task_loader.sv
// Self-checking bench for core_task_loader: scripted tasks with an
// expected-frame queue for fetch reads.
module tb_core_task_loader;

  localparam int CID = 2;
  localparam int NC  = 4;
  localparam int FW  = 64;
  localparam int RW  = 8;
  localparam int BD  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     Start;
  logic [FW-1:0]     Insn_Data;
  logic [NC-1:0]     Init_R0_Vect;
  logic [NC*RW-1:0]  Init_R0;
  logic              Ready;
  logic [2:0]        fetch_addr;
  logic [FW-1:0]     fetch_data;
  logic              r0_we;
  logic [RW-1:0]     r0_data;
  logic              core_run;
  logic              core_halt;
  logic [3:0]        frame_cnt;
  logic [1:0]        err;

  int n_checks = 0;
  int n_errors = 0;
  int run_cnt  = 0;
  int r0_cnt   = 0;

  logic [FW-1:0] model [BD];
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] expd;

  core_task_loader #(
    .CORE_ID(CID), .NUM_CORES(NC), .FRAME_W(FW), .REG_W(RW), .BUF_DEPTH(BD), .STOP_OP(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .Start(Start), .Insn_Data(Insn_Data),
    .Init_R0_Vect(Init_R0_Vect), .Init_R0(Init_R0), .Ready(Ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .r0_we(r0_we),
    .r0_data(r0_data), .core_run(core_run), .core_halt(core_halt),
    .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse counters (sampled on the rising edge, before outputs update)
  always @(posedge clk) begin
    if (core_run) run_cnt++;
    if (r0_we)    r0_cnt++;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // One Start cycle for this core; other cores' bits carry noise.
  // idx >= 0 records the frame the loader is expected to store there.
  task automatic drive_frame(input logic [FW-1:0] d, input logic v, input int idx);
    Start = NC'($urandom); Start[CID] = 1'b1;
    Init_R0_Vect = NC'($urandom); Init_R0_Vect[CID] = v;
    Insn_Data = d;
    if (idx >= 0) model[idx] = d;
    @(negedge clk);
    Start = NC'($urandom); Start[CID] = 1'b0;
    Init_R0_Vect = NC'($urandom); Init_R0_Vect[CID] = 1'b0;
    Insn_Data = {$urandom, $urandom};
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (Ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b expected 1", Ready); end
    n_checks++; if (err !== 2'b00) begin n_errors++; $display("FAIL rst_err: got %b expected 00", err); end
    n_checks++; if (core_run !== 1'b0) begin n_errors++; $display("FAIL rst_run: got %b expected 0", core_run); end
    n_checks++; if (r0_we !== 1'b0 || r0_data !== 8'h00) begin n_errors++; $display("FAIL rst_r0: got %b/%h expected 0/00", r0_we, r0_data); end
    n_checks++; if (frame_cnt !== 4'd0) begin n_errors++; $display("FAIL rst_cnt: got %0d expected 0", frame_cnt); end
    n_checks++; if (fetch_data !== '0) begin n_errors++; $display("FAIL rst_fetch: got %h expected 0", fetch_data); end
    reset = 1'b1;
    repeat (4) tick();
    n_checks++; if (Ready !== 1'b1 || err !== 2'b00 || core_run !== 1'b0 || run_cnt != 0) begin
      n_errors++; $display("FAIL idle_quiet: got ready=%b err=%b run=%b runs=%0d expected 1/00/0/0", Ready, err, core_run, run_cnt); end
  endtask

  task automatic test_basic;
    run_cnt = 0; r0_cnt = 0;
    drive_frame(64'h0100_0000_AAAA_0001, 1'b1, 0);
    n_checks++; if (Ready !== 1'b0) begin n_errors++; $display("FAIL basic_ready0: got %b expected 0", Ready); end
    n_checks++; if (r0_we !== 1'b1 || r0_data !== 8'h5A) begin n_errors++; $display("FAIL basic_r0: got %b/%h expected 1/5a", r0_we, r0_data); end
    n_checks++; if (frame_cnt !== 4'd1) begin n_errors++; $display("FAIL basic_cnt1: got %0d expected 1", frame_cnt); end
    tick();
    n_checks++; if (Ready !== 1'b1 || r0_we !== 1'b0) begin n_errors++; $display("FAIL basic_ready1: got %b/%b expected 1/0", Ready, r0_we); end
    drive_frame(64'h0200_0000_BBBB_0002, 1'b0, 1);
    n_checks++; if (Ready !== 1'b0 || frame_cnt !== 4'd2) begin n_errors++; $display("FAIL basic_f2: got %b/%0d expected 0/2", Ready, frame_cnt); end
    tick();
    n_checks++; if (Ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready3: got %b expected 1", Ready); end
    drive_frame(64'hFF00_0000_CCCC_0003, 1'b0, 2);
    n_checks++; if (Ready !== 1'b0 || frame_cnt !== 4'd3 || core_run !== 1'b0) begin
      n_errors++; $display("FAIL basic_f3: got %b/%0d/%b expected 0/3/0", Ready, frame_cnt, core_run); end
    tick();
    n_checks++; if (core_run !== 1'b1 || Ready !== 1'b0) begin n_errors++; $display("FAIL basic_run: got %b/%b expected 1/0", core_run, Ready); end
    tick();
    n_checks++; if (core_run !== 1'b0 || run_cnt != 1 || r0_cnt != 1) begin
      n_errors++; $display("FAIL basic_pulses: got run=%b runs=%0d r0s=%0d expected 0/1/1", core_run, run_cnt, r0_cnt); end
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 3'(i); exp_q.push_back(model[i]); tick(); expd = exp_q.pop_front();
      n_checks++; if (fetch_data !== expd) begin n_errors++; $display("FAIL basic_fetch%0d: got %h expected %h", i, fetch_data, expd); end
    end
  endtask

  task automatic test_start_in_run;
    drive_frame(64'h0900_DEAD_BEEF_0009, 1'b0, -1);
    n_checks++; if (err !== 2'b10 || Ready !== 1'b0 || frame_cnt !== 4'd3) begin
      n_errors++; $display("FAIL run_start: got err=%b ready=%b cnt=%0d expected 10/0/3", err, Ready, frame_cnt); end
    tick();
    n_checks++; if (Ready !== 1'b0) begin n_errors++; $display("FAIL run_ready: got %b expected 0", Ready); end
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 3'(i); exp_q.push_back(model[i]); tick(); expd = exp_q.pop_front();
      n_checks++; if (fetch_data !== expd) begin n_errors++; $display("FAIL run_fetch%0d: got %h expected %h", i, fetch_data, expd); end
    end
  endtask

  task automatic test_halt;
    run_cnt = 0;
    core_halt = 1'b1; tick(); core_halt = 1'b0;
    n_checks++; if (Ready !== 1'b1 || frame_cnt !== 4'd0) begin n_errors++; $display("FAIL halt: got %b/%0d expected 1/0", Ready, frame_cnt); end
    drive_frame(64'h0300_0000_DDDD_0004, 1'b0, 0);
    n_checks++; if (frame_cnt !== 4'd1 || Ready !== 1'b0) begin n_errors++; $display("FAIL halt_reload: got %0d/%b expected 1/0", frame_cnt, Ready); end
    tick();
    drive_frame(64'hFF00_0000_EEEE_0005, 1'b0, 1);
    n_checks++; if (frame_cnt !== 4'd2) begin n_errors++; $display("FAIL halt_cnt2: got %0d expected 2", frame_cnt); end
    tick(); tick();
    n_checks++; if (run_cnt != 1) begin n_errors++; $display("FAIL halt_run: got %0d expected 1", run_cnt); end
    // halt and Start together: halt wins, frame dropped, err[1] flagged
    core_halt = 1'b1;
    drive_frame(64'h0700_0BAD_0BAD_0007, 1'b0, -1);
    core_halt = 1'b0;
    n_checks++; if (Ready !== 1'b1 || frame_cnt !== 4'd0 || err[1] !== 1'b1) begin
      n_errors++; $display("FAIL halt_start: got %b/%0d/%b expected 1/0/1", Ready, frame_cnt, err[1]); end
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 3'(i); exp_q.push_back(model[i]); tick(); expd = exp_q.pop_front();
      n_checks++; if (fetch_data !== expd) begin n_errors++; $display("FAIL halt_fetch%0d: got %h expected %h", i, fetch_data, expd); end
    end
  endtask

  task automatic test_overflow;
    logic [FW-1:0] f;
    do_reset();
    run_cnt = 0;
    for (int i = 0; i < BD; i++) begin
      f = {8'(32 + i), 24'hC0FFEE, $urandom};
      drive_frame(f, 1'b0, i);
      n_checks++; if (frame_cnt !== 4'(i + 1) || Ready !== 1'b0) begin
        n_errors++; $display("FAIL ovf_cnt%0d: got %0d/%b expected %0d/0", i, frame_cnt, Ready, i + 1); end
      if (i < BD - 1) begin
        n_checks++; if (err !== 2'b00) begin n_errors++; $display("FAIL ovf_early%0d: got %b expected 00", i, err); end
      end
    end
    n_checks++; if (err !== 2'b01) begin n_errors++; $display("FAIL ovf_err: got %b expected 01", err); end
    tick();
    n_checks++; if (core_run !== 1'b1) begin n_errors++; $display("FAIL ovf_run: got %b expected 1", core_run); end
    drive_frame(64'h0800_1111_2222_3333, 1'b0, -1);
    n_checks++; if (frame_cnt !== 4'd8 || err !== 2'b11) begin n_errors++; $display("FAIL ovf_sat: got %0d/%b expected 8/11", frame_cnt, err); end
    for (int i = 0; i < BD; i++) begin
      fetch_addr = 3'(i); exp_q.push_back(model[i]); tick(); expd = exp_q.pop_front();
      n_checks++; if (fetch_data !== expd) begin n_errors++; $display("FAIL ovf_fetch%0d: got %h expected %h", i, fetch_data, expd); end
    end
    core_halt = 1'b1; tick(); core_halt = 1'b0;
  endtask

  task automatic test_reset_mid_load;
    run_cnt = 0; r0_cnt = 0;
    drive_frame(64'h0400_0000_5555_0001, 1'b1, -1);
    tick();
    drive_frame(64'h0500_0000_6666_0002, 1'b0, -1);
    n_checks++; if (Ready !== 1'b0 || frame_cnt !== 4'd2) begin n_errors++; $display("FAIL mid_pre: got %b/%0d expected 0/2", Ready, frame_cnt); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (Ready !== 1'b1 || frame_cnt !== 4'd0 || err !== 2'b00) begin
      n_errors++; $display("FAIL mid_async: got %b/%0d/%b expected 1/0/00", Ready, frame_cnt, err); end
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (run_cnt != 0) begin n_errors++; $display("FAIL mid_norun: got %0d expected 0", run_cnt); end
    r0_cnt = 0;
    drive_frame(64'hFF00_0000_7777_0003, 1'b0, 0);
    n_checks++; if (frame_cnt !== 4'd1 || r0_we !== 1'b0) begin n_errors++; $display("FAIL mid_stop: got %0d/%b expected 1/0", frame_cnt, r0_we); end
    tick();
    n_checks++; if (core_run !== 1'b1) begin n_errors++; $display("FAIL mid_run: got %b expected 1", core_run); end
    fetch_addr = 3'd0; exp_q.push_back(model[0]); tick(); expd = exp_q.pop_front();
    n_checks++; if (fetch_data !== expd || r0_cnt != 0) begin
      n_errors++; $display("FAIL mid_fetch: got %h r0s=%0d expected %h r0s=0", fetch_data, r0_cnt, expd); end
  endtask

  initial begin
    reset = 1'b0; Start = '0; Insn_Data = '0; Init_R0_Vect = '0;
    Init_R0 = 32'h115A_3344; fetch_addr = '0; core_halt = 1'b0;
    test_reset();
    test_basic();
    test_start_in_run();
    test_halt();
    test_overflow();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
